// File: rtl/conv_row_sched_if.sv
// rtl/conv_row_sched_if.sv - DRAM row-read and PE line-pass handshake bundle
// Master side is the scheduler: it raises the row request and compute
// enable; slave side acknowledges reads and reports line-pass completion.
interface conv_row_sched_if #(
  parameter int LITEWIDTH = 32
) ();
  logic                 O_rd_req;
  logic [LITEWIDTH-1:0] O_rd_addr;
  logic                 I_rd_ack;
  logic                 O_compute_en;
  logic                 I_line_done;

  modport master (
    output O_rd_req,
    output O_rd_addr,
    output O_compute_en,
    input  I_rd_ack,
    input  I_line_done
  );

  modport slave (
    input  O_rd_req,
    input  O_rd_addr,
    input  O_compute_en,
    output I_rd_ack,
    output I_line_done
  );
endinterface

// File: rtl/conv_row_sched.sv
// rtl/conv_row_sched.sv - convolution (h,kh) row walker and DRAM row-read scheduler (optional macro: DILATION_EN)
// Walks every (output row, kernel row) pair of a layer, maps it to an input
// row through stride/padding/dilation, requests that row from DRAM and holds
// compute enable until the PE array finishes the line pass. Pairs that land
// in padding produce a one-cycle pad pulse instead of a read.
module conv_row_sched #(
  parameter int W_WIDTH   = 12,
  parameter int KWIDTH    = 4,
  parameter int SWIDTH    = 3,
  parameter int PWIDTH    = 3,
  parameter int LITEWIDTH = 32,
  parameter int DLWIDTH   = 3
) (
  input  logic                 I_clk,
  input  logic                 I_rst_n,
  input  logic                 I_ap_start,
  input  logic [W_WIDTH-1:0]   I_oheight,
  input  logic [W_WIDTH-1:0]   I_iheight,
  input  logic [KWIDTH-1:0]    I_kernel_h,
  input  logic [SWIDTH-1:0]    I_stride_h,
  input  logic [PWIDTH-1:0]    I_pad_h,
  input  logic [DLWIDTH-1:0]   I_dilation_h,
  input  logic [LITEWIDTH-1:0] I_feature_base_addr,
  input  logic [LITEWIDTH-1:0] I_line_bytes,
  conv_row_sched_if.master     rd_if,
  output logic [W_WIDTH-1:0]   O_h,
  output logic [KWIDTH-1:0]    O_kh,
  output logic [W_WIDTH-1:0]   O_hindex,
  output logic                 O_pad_row,
  output logic                 O_last_line,
  output logic                 O_busy,
  output logic                 O_done
);

  // Signed input-row arithmetic width: three guard bits above the row counters.
  localparam int HW = W_WIDTH + 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_PAD,
    S_REQ,
    S_RUN,
    S_NEXT,
    S_FIN
  } state_t;

  state_t r_state;
  state_t w_next;

  // Layer configuration captured at start.
  logic [W_WIDTH-1:0]   r_oheight;
  logic [W_WIDTH-1:0]   r_iheight;
  logic [KWIDTH-1:0]    r_kernel_h;
  logic [SWIDTH-1:0]    r_stride;
  logic [PWIDTH-1:0]    r_pad;
  logic [LITEWIDTH-1:0] r_base;
  logic [LITEWIDTH-1:0] r_line_bytes;

  // Walk position and per-pair results.
  logic [W_WIDTH-1:0]   r_h;
  logic [KWIDTH-1:0]    r_kh;
  logic [W_WIDTH-1:0]   r_hindex;
  logic [LITEWIDTH-1:0] r_rd_addr;
  logic                 r_busy_tail;

  logic                 w_start;
  logic                 w_empty;
  logic                 w_kh_last;
  logic                 w_last_pair;
  logic [HW-1:0]        w_h_term;
  logic [HW-1:0]        w_kh_term;
  logic [HW-1:0]        w_hidx;
  logic                 w_oob;
  logic [LITEWIDTH-1:0] w_addr;

  // A new layer is accepted only once the busy tail after the previous one has cleared.
  assign w_start     = (r_state == S_IDLE) && !r_busy_tail && I_ap_start;
  assign w_empty     = (I_oheight == '0) || (I_kernel_h == '0);
  assign w_kh_last   = (r_kh == r_kernel_h - KWIDTH'(1));
  assign w_last_pair = w_kh_last && (r_h == r_oheight - W_WIDTH'(1));

  assign w_h_term = HW'(r_h) * HW'(r_stride);

`ifdef DILATION_EN
  logic [DLWIDTH-1:0]        r_dil;
  logic [KWIDTH+DLWIDTH-1:0] w_kh_dil;

  // Dilation is latched with the rest of the layer configuration; zero means one.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_dil <= '0;
    end else if (w_start) begin
      r_dil <= (I_dilation_h == '0) ? DLWIDTH'(1) : I_dilation_h;
    end
  end

  assign w_kh_dil  = (KWIDTH+DLWIDTH)'(r_kh) * (KWIDTH+DLWIDTH)'(r_dil);
  assign w_kh_term = HW'(w_kh_dil);
`else
  logic w_unused_dil;

  assign w_unused_dil = ^I_dilation_h;
  assign w_kh_term    = HW'(r_kh);
`endif

  // Negative results wrap to a set sign bit, which marks a top-padding row.
  assign w_hidx = w_h_term + w_kh_term - HW'(r_pad);
  assign w_oob  = w_hidx[HW-1] || (w_hidx >= HW'(r_iheight));
  assign w_addr = r_base + LITEWIDTH'(w_hidx[W_WIDTH-1:0]) * r_line_bytes;

  // Capture layer configuration at start so mid-layer input changes have no effect.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_oheight    <= '0;
      r_iheight    <= '0;
      r_kernel_h   <= '0;
      r_stride     <= '0;
      r_pad        <= '0;
      r_base       <= '0;
      r_line_bytes <= '0;
    end else if (w_start) begin
      r_oheight    <= I_oheight;
      r_iheight    <= I_iheight;
      r_kernel_h   <= I_kernel_h;
      r_stride     <= (I_stride_h == '0) ? SWIDTH'(1) : I_stride_h;
      r_pad        <= I_pad_h;
      r_base       <= I_feature_base_addr;
      r_line_bytes <= I_line_bytes;
    end
  end

  // Advance the (h,kh) walk: clear on start, step kh then h in NEXT.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_h  <= '0;
      r_kh <= '0;
    end else if (w_start) begin
      r_h  <= '0;
      r_kh <= '0;
    end else if (r_state == S_NEXT) begin
      if (w_kh_last) begin
        r_kh <= '0;
        r_h  <= r_h + W_WIDTH'(1);
      end else begin
        r_kh <= r_kh + KWIDTH'(1);
      end
    end
  end

  // Register input row and DRAM address of a valid pair so they stay stable through REQ and RUN.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_hindex  <= '0;
      r_rd_addr <= '0;
    end else if ((r_state == S_CALC) && !w_oob) begin
      r_hindex  <= w_hidx[W_WIDTH-1:0];
      r_rd_addr <= w_addr;
    end
  end

  // Keep busy asserted for one cycle after the done pulse.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_busy_tail <= 1'b0;
    end else begin
      r_busy_tail <= (r_state == S_FIN);
    end
  end

  // State register.
  always_ff @(posedge I_clk or negedge I_rst_n) begin
    if (!I_rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state and per-state strobes; ack wins over line_done in REQ because only RUN looks at line_done.
  always_comb begin
    w_next             = r_state;
    O_pad_row          = 1'b0;
    O_done             = 1'b0;
    rd_if.O_rd_req     = 1'b0;
    rd_if.O_compute_en = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next = w_empty ? S_FIN : S_CALC;
        end
      end
      S_CALC: begin
        w_next = w_oob ? S_PAD : S_REQ;
      end
      S_PAD: begin
        O_pad_row = 1'b1;
        w_next    = S_NEXT;
      end
      S_REQ: begin
        rd_if.O_rd_req = 1'b1;
        if (rd_if.I_rd_ack) begin
          w_next = S_RUN;
        end
      end
      S_RUN: begin
        rd_if.O_compute_en = 1'b1;
        if (rd_if.I_line_done) begin
          w_next = S_NEXT;
        end
      end
      S_NEXT: begin
        w_next = w_last_pair ? S_FIN : S_CALC;
      end
      S_FIN: begin
        O_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  assign rd_if.O_rd_addr = r_rd_addr;
  assign O_h             = r_h;
  assign O_kh            = r_kh;
  assign O_hindex        = r_hindex;
  assign O_busy          = (r_state != S_IDLE) || r_busy_tail;
  assign O_last_line     = O_busy && (r_h == r_oheight - W_WIDTH'(1));

endmodule
